// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
//
// Host-to-device PS/2 transmitter. It sends one command byte to the keyboard
// over the shared open-drain clock/data pair using the standard host request
// sequence:
//  1. Inhibit: hold the clock low.
//  2. Request: pull data low (the start bit) while the clock is still held.
//  3. Release the clock. The device then generates 11 clocks. On each falling
//     clock edge the host presents the next bit. The 11th edge samples the
//     device acknowledge.
//  4. Wait for the bus to go idle, then report completion.
//
// Ports
//  clk           in   system clock
//  rst_n         in   asynchronous active-low reset
//  tx_data       in   byte to send
//  tx_valid      in   send request, accepted when tx_valid & tx_ready
//  tx_ready      out  high only while idle
//  ps2k_clk      in   PS/2 clock line as seen at the pad
//  ps2k_data     in   PS/2 data line as seen at the pad
//  ps2k_clk_oe   out  1 = pull the PS/2 clock low, 0 = release
//  ps2k_data_oe  out  1 = pull the PS/2 data low, 0 = release
//  busy          out  high from accept until the return to idle
//  tx_done       out  one-cycle pulse at frame end (success or failure)
//  tx_err        out  valid with tx_done: 1 = no acknowledge or timeout
// ---------------------------------------------------------------------------
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int SETUP_CYCLES   = 50,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2k_clk,
    input  logic       ps2k_data,
    output logic       ps2k_clk_oe,
    output logic       ps2k_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err
);

    // One counter times both the inhibit phase and the request phase.
    // It is sized for the longer of the two.
    localparam int PHASE_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int PW        = $clog2(PHASE_MAX + 1);
    localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [PW-1:0] INHIBIT_LAST = PW'(INHIBIT_CYCLES - 1);
    localparam logic [PW-1:0] SETUP_LAST   = PW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_REQUEST,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t          state_reg;
    logic [7:0]      shift_reg;
    logic            parity_reg;
    logic [3:0]      bit_cnt_reg;
    logic [PW-1:0]   phase_cnt_reg;
    logic [TW-1:0]   to_cnt_reg;
    logic            nack_reg;

    logic            clk_oe_reg;
    logic            data_oe_reg;
    logic            busy_reg;
    logic            ready_reg;
    logic            done_reg;
    logic            err_reg;

    // Pad synchronisers. They reset to 1 (idle bus) so that coming out of
    // reset never produces a false falling edge.
    logic            clk_r0_reg;
    logic            clk_r1_reg;
    logic            clk_r2_reg;
    logic            data_r0_reg;
    logic            data_r1_reg;
    logic            fall;

    assign fall = ~clk_r1_reg & clk_r2_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_r0_reg  <= 1'b1;
            clk_r1_reg  <= 1'b1;
            clk_r2_reg  <= 1'b1;
            data_r0_reg <= 1'b1;
            data_r1_reg <= 1'b1;
        end else begin
            clk_r0_reg  <= ps2k_clk;
            clk_r1_reg  <= clk_r0_reg;
            clk_r2_reg  <= clk_r1_reg;
            data_r0_reg <= ps2k_data;
            data_r1_reg <= data_r0_reg;
        end
    end

    // Main FSM. All outputs are registered here.
    // Because the reset is asynchronous, the bus lines are released at the
    // instant rst_n falls, even in the middle of a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            shift_reg     <= 8'h00;
            parity_reg    <= 1'b0;
            bit_cnt_reg   <= 4'd0;
            phase_cnt_reg <= '0;
            to_cnt_reg    <= '0;
            nack_reg      <= 1'b0;
            clk_oe_reg    <= 1'b0;
            data_oe_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            ready_reg     <= 1'b1;
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
        end else begin
            // tx_done and tx_err are pulses. Each assertion below lasts one cycle.
            done_reg <= 1'b0;
            err_reg  <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (tx_valid) begin
                        shift_reg     <= tx_data;
                        parity_reg    <= ~^tx_data;   // odd parity
                        bit_cnt_reg   <= 4'd0;
                        phase_cnt_reg <= '0;
                        clk_oe_reg    <= 1'b1;
                        data_oe_reg   <= 1'b0;
                        busy_reg      <= 1'b1;
                        ready_reg     <= 1'b0;
                        state_reg     <= ST_INHIBIT;
                    end
                end

                ST_INHIBIT: begin
                    if (phase_cnt_reg == INHIBIT_LAST) begin
                        phase_cnt_reg <= '0;
                        data_oe_reg   <= 1'b1;        // start bit
                        state_reg     <= ST_REQUEST;
                    end else begin
                        phase_cnt_reg <= phase_cnt_reg + PW'(1);
                    end
                end

                ST_REQUEST: begin
                    if (phase_cnt_reg == SETUP_LAST) begin
                        clk_oe_reg <= 1'b0;           // hand the clock to the device
                        to_cnt_reg <= '0;
                        state_reg  <= ST_SEND;
                    end else begin
                        phase_cnt_reg <= phase_cnt_reg + PW'(1);
                    end
                end

                ST_SEND: begin
                    // The timeout is checked first, so it wins over a falling
                    // edge that arrives in the same cycle.
                    if (to_cnt_reg == TIMEOUT_LAST) begin
                        clk_oe_reg  <= 1'b0;
                        data_oe_reg <= 1'b0;
                        done_reg    <= 1'b1;
                        err_reg     <= 1'b1;
                        busy_reg    <= 1'b0;
                        ready_reg   <= 1'b1;
                        state_reg   <= ST_IDLE;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + TW'(1);
                        if (fall) begin
                            // bit_cnt_reg holds the number of falls seen so far.
                            // Fall n therefore sees the value n-1.
                            bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            case (bit_cnt_reg)
                                4'd0, 4'd1, 4'd2, 4'd3,
                                4'd4, 4'd5, 4'd6, 4'd7:
                                    data_oe_reg <= ~shift_reg[bit_cnt_reg[2:0]];
                                4'd8:
                                    data_oe_reg <= ~parity_reg;
                                4'd9:
                                    data_oe_reg <= 1'b0;      // stop bit
                                default: begin
                                    // 11th fall: the device acknowledges by
                                    // pulling data low.
                                    data_oe_reg <= 1'b0;
                                    nack_reg    <= data_r1_reg;
                                    state_reg   <= ST_WAIT;
                                end
                            endcase
                        end
                    end
                end

                ST_WAIT: begin
                    if (to_cnt_reg == TIMEOUT_LAST) begin
                        clk_oe_reg  <= 1'b0;
                        data_oe_reg <= 1'b0;
                        done_reg    <= 1'b1;
                        err_reg     <= 1'b1;
                        busy_reg    <= 1'b0;
                        ready_reg   <= 1'b1;
                        state_reg   <= ST_IDLE;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + TW'(1);
                        // Leave only once the device has let go of both lines.
                        if (clk_r2_reg && data_r1_reg) begin
                            done_reg  <= 1'b1;
                            err_reg   <= nack_reg;
                            state_reg <= ST_DONE;
                        end
                    end
                end

                ST_DONE: begin
                    busy_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                    state_reg <= ST_IDLE;
                end

                default: begin
                    clk_oe_reg  <= 1'b0;
                    data_oe_reg <= 1'b0;
                    busy_reg    <= 1'b0;
                    ready_reg   <= 1'b1;
                    state_reg   <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_ready     = ready_reg;
    assign ps2k_clk_oe  = clk_oe_reg;
    assign ps2k_data_oe = data_oe_reg;
    assign busy         = busy_reg;
    assign tx_done      = done_reg;
    assign tx_err       = err_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_tx
//
// Bench for ps2_host_tx. It uses shortened timing parameters.
//  - A device BFM generates the PS/2 clock, captures the frame on rising
//    edges, and optionally acknowledges.
//  - A per-cycle compare process checks the inhibit/request timeline,
//    tx_ready/busy consistency, the tx_done pulse shape, and the return to
//    idle.
//  - The expected frame is start 0, LSB-first data, odd parity, stop 1.
// ---------------------------------------------------------------------------
module tb_ps2_host_tx;

    localparam int I = 60;   // inhibit cycles
    localparam int S = 12;   // setup cycles
    localparam int T = 800;  // timeout cycles
    localparam int H = 15;   // BFM half period in clk cycles

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;

    wire tx_ready;
    wire clk_oe;
    wire data_oe;
    wire busy;
    wire tx_done;
    wire tx_err;

    // Open-drain bus: a line is low if either side pulls it.
    wire ps2k_clk  = ~(clk_oe | dev_clk_low);
    wire ps2k_data = ~(data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES(I),
        .SETUP_CYCLES  (S),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2k_clk    (ps2k_clk),
        .ps2k_data   (ps2k_data),
        .ps2k_clk_oe (clk_oe),
        .ps2k_data_oe(data_oe),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model of the frame the device must see.
    // Bit 0 is the start bit and bit 10 the stop bit.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    // ---------------- per-cycle compare process ----------------
    bit phase_active = 0;
    int phase_n      = 0;
    int done_cnt     = 0;
    int done_n       = 0;
    bit done_err     = 0;
    int acc_cnt      = 0;
    bit prev_done    = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            phase_active = 0;
            prev_done    = 0;
        end else begin
            chk("ready_vs_busy", tx_ready, !busy);
            if (phase_active) begin
                phase_n++;
                if (phase_n <= I + S) begin
                    chk("hold_clk_oe", clk_oe, 1);
                    chk("hold_data_oe", data_oe, (phase_n > I));
                end else if (phase_n == I + S + 1) begin
                    chk("clk_release", clk_oe, 0);
                end
            end
            if (prev_done) begin
                chk("done_one_cycle", tx_done, 0);
                chk("busy_after_done", busy, 0);
            end
            if (tx_done) begin
                done_cnt++;
                done_err = tx_err;
                done_n   = phase_n;
                chk("done_lines_released", {clk_oe, data_oe}, 2'b00);
                if (!tx_err) chk("busy_during_done", busy, 1);
            end
            prev_done = tx_done;
            if (tx_valid && tx_ready) begin
                phase_active = 1;
                phase_n      = 0;
                acc_cnt++;
            end
        end
    end

    // ---------------- device BFM ----------------
    task automatic bfm(input int nclk, input bit ack, input bit pulse,
                       output logic [10:0] cap, output bit ok);
        int w;
        w   = 0;
        cap = '1;
        ok  = 0;
        while (!(ps2k_clk === 1'b1 && ps2k_data === 1'b0) && w < I + S + 50) begin
            @(negedge clk);
            w++;
        end
        if (ps2k_clk === 1'b1 && ps2k_data === 1'b0) ok = 1;
        if (!ok) return;
        cap[0] = ps2k_data;
        repeat (H) @(negedge clk);
        for (int i = 1; i <= nclk; i++) begin
            dev_clk_low = 1'b1;
            if (i == 11 && ack) dev_data_low = 1'b1;
            if (pulse && i == 4) begin
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                chk("ready_in_send", tx_ready, 0);
            end
            repeat (H) @(negedge clk);
            tx_valid = 1'b0;
            if (i <= 10) cap[i] = ps2k_data;   // device samples on the rising edge
            dev_clk_low = 1'b0;
            repeat (H) @(negedge clk);
            dev_data_low = 1'b0;
        end
    endtask

    task automatic start_frame(input logic [7:0] b);
        @(negedge clk);
        chk("ready_before", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic run_frame(input logic [7:0] b, input int nclk, input bit ack,
                             input bit pulse, input int pin_par);
        logic [10:0] cap;
        bit          ok;
        int          base_done;
        int          base_acc;
        int          w;
        bit          exp_err;
        base_done = done_cnt;
        base_acc  = acc_cnt;
        start_frame(b);
        bfm(nclk, ack, pulse, cap, ok);
        chk("request_seen", ok, 1);
        if (nclk == 11) chk("frame_bits", cap, model_frame(b));
        if (pin_par >= 0) chk("pinned_parity", cap[9], pin_par[0]);
        w = 0;
        while (done_cnt == base_done && w < T + 100) begin
            @(negedge clk);
            w++;
        end
        chk("done_count", done_cnt - base_done, 1);
        exp_err = !ack || (nclk < 11);
        chk("tx_err", done_err, exp_err);
        if (nclk == 0) chk("timeout_latency", done_n, I + S + T + 1);
        repeat (3) @(negedge clk);
        chk("idle_lines", {clk_oe, data_oe, busy, tx_ready}, 4'b0001);
        chk("accept_count", acc_cnt - base_acc, 1);
        $display("frame byte=%02h clocks=%0d ack=%0d cap=%03h err=%0d", b, nclk, ack, cap, done_err);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] cap;
        bit          ok;
        int          base_done;

        repeat (3) @(negedge clk);
        chk("reset_outputs", {clk_oe, data_oe, busy, tx_done, tx_err, tx_ready}, 6'b000001);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        run_frame(8'hED, 11, 1, 0, 1);
        run_frame(8'h01, 11, 1, 0, 0);
        run_frame(8'h00, 11, 1, 0, 1);
        run_frame(8'hA5, 11, 0, 0, -1);   // no acknowledge
        run_frame(8'h3C, 0,  1, 0, -1);   // device never clocks
        run_frame(8'h96, 11, 1, 1, -1);   // 8'h55 offered mid-frame
        for (int k = 0; k < 10; k++) begin
            run_frame(8'($urandom), 11, ($urandom_range(0, 3) != 0), 0, -1);
        end

        // Reset after the 5th data bit: the lines must release at once.
        base_done = done_cnt;
        start_frame(8'h00);
        bfm(6, 1, 0, cap, ok);
        chk("rst_request_seen", ok, 1);
        chk("pre_reset_data_oe", data_oe, 1);
        #2 rst_n = 1'b0;
        #1 chk("async_release_send", {clk_oe, data_oe}, 2'b00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_reset_ready", tx_ready, 1);
        chk("post_reset_no_done", done_cnt - base_done, 0);
        $display("frame byte=00 reset after bit 5");

        // Reset during the inhibit phase releases the clock line.
        start_frame(8'hC3);
        repeat (20) @(negedge clk);
        chk("inhibit_clk_oe", clk_oe, 1);
        #2 rst_n = 1'b0;
        #1 chk("async_release_inhibit", {clk_oe, data_oe, tx_ready}, 3'b001);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        $display("frame byte=c3 reset during inhibit");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
